updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
- Parametrised up/down modulo counter; next generation of the team's fixed 3-bit down counter.
- Adds configurable width and modulus, direction control, parallel load, and a wrap or saturate mode.
- Adds an enable with an integrated prescaler and a registered terminal-count pulse.
- Used as a general timer/event counter wherever a plain free-running counter is insufficient.

Parameters:
- WIDTH, 8, counter width in bits (>=1).
- MOD_MAX, 255, highest count value; range is 0..MOD_MAX; must satisfy MOD_MAX <= 2**WIDTH-1.
- RESET_VAL, MOD_MAX, count value after reset; must be <= MOD_MAX.
- PRESCALE, 1, number of enabled cycles per count step (>=1); 1 = step on every enabled cycle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous reset, active-low: sampled at rising edge of clk; 0 = reset.
- en  in  1  count enable; gates the prescaler and stepping.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  boundary mode: 1 = saturate, 0 = wrap.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  registered count.
- tc  out  1  registered one-cycle pulse: a step was taken at a boundary.
- at_zero  out  1  combinational, count == 0.
- at_max  out  1  combinational, count == MOD_MAX.

Behaviour:
- Priority per rising edge: reset (low) > load > step > hold.
- Reset (reset==0 at edge): count=RESET_VAL, prescaler=0, tc=0. at_zero/at_max follow RESET_VAL. Overrides load and en in the same cycle.
- Load (load==1):
  - count = load_val if load_val <= MOD_MAX, else count = MOD_MAX (clamp).
  - prescaler=0, tc=0. en ignored that cycle.
- Prescaler:
  - Internal counter of width max(1, clog2(PRESCALE)).
  - en==1 and no load: if prescaler == PRESCALE-1 then prescaler=0 and a step occurs; else prescaler+1 and no step.
  - en==0: prescaler and count hold, tc=0.
  - PRESCALE=1: every enabled cycle steps.
- Step, up==1:
  - count < MOD_MAX: count+1, tc=0.
  - count == MOD_MAX: wrap mode gives count=0, tc=1; sat mode holds MOD_MAX, tc=1.
- Step, up==0:
  - count > 0: count-1, tc=0.
  - count == 0: wrap mode gives count=MOD_MAX, tc=1; sat mode holds 0, tc=1.
- tc:
  - High exactly one cycle after each boundary step, i.e. in the same cycle count shows the wrapped or held value.
  - In sat mode it pulses on every boundary step while en is held.
  - Cycles with no step: tc=0.
- Latency: count reflects a step, load or reset one clock after the qualifying edge. No combinational path from inputs to count or tc.
- up and sat are sampled only on step edges. Changing them mid-prescale affects only the next step; the prescaler is not cleared.
- count never exceeds MOD_MAX under any input sequence.
- All arithmetic is WIDTH bits. Boundary detection uses the comparisons count==0 and count==MOD_MAX, never carry or borrow, so non-power-of-2 MOD_MAX wraps correctly.
- Default parameters with en=1, up=0, sat=0, PRESCALE=1 reproduce a free-running down counter from max, apart from reset polarity.

Test Plan:
- WIDTH=3, MOD_MAX=7, defaults: reset=0 for 2 cycles, then en=1, up=0, sat=0 -> count 7,6,...,0,7; tc=1 only in the cycle count returns to 7.
- WIDTH=4, MOD_MAX=9: load=1, load_val=8, then up=1, en=1 -> 8,9,0,1; tc high with count=0. Separately load_val=14 -> count=9 (clamp).
- MOD_MAX=9, sat=1, up=0 from count=1 with en=1 for 4 cycles -> 0,0,0,0; tc=0,1,1,1; at_zero=1 from the first 0.
- PRESCALE=3, en=1, up=1 from 0 -> count changes every 3rd cycle (0,0,0,1,1,1,2). Dropping en for 2 cycles mid-prescale stretches the interval by exactly 2.
- Simultaneous events: reset=0 with load=1, load_val=2 -> count=RESET_VAL. Then load=1 with en=1 at a boundary -> count=load_val, tc=0, prescaler cleared.
- Mid-operation: reset asserted during up count at 5 -> next cycle count=RESET_VAL, tc=0; counting resumes one cycle after release.

Source files
------------

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with prescaler, load and terminal count
//
// Purpose: general timer/event counter. Counts 0..MOD_MAX up or down, wrapping or
// saturating at the boundaries, with a parallel load (clamped to MOD_MAX) and an
// enable that feeds a PRESCALE-cycle prescaler before each count step.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   en       in   count enable (gates prescaler and stepping)
//   up       in   1 = increment, 0 = decrement
//   sat      in   1 = saturate at boundary, 0 = wrap
//   load     in   parallel load strobe
//   load_val in   value to load (clamped to MOD_MAX)
//   count    out  registered count
//   tc       out  registered one-cycle pulse after a boundary step
//   at_zero  out  count == 0
//   at_max   out  count == MOD_MAX
module updown_mod_counter #(
  parameter int WIDTH     = 8,
  parameter int MOD_MAX   = 255,
  parameter int RESET_VAL = MOD_MAX,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_zero,
  output logic             at_max
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_V  = '0;
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler;

  // With PRESCALE=1 the prescaler is stuck at 0 == PS_LAST, so every enabled cycle steps.
  logic step;
  assign step = en && (prescaler == PS_LAST);

  assign at_zero = (count == ZERO_V);
  assign at_max  = (count == MAX_V);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= RST_V;
      prescaler <= '0;
      tc        <= 1'b0;
    end else if (load) begin
      count     <= (load_val > MAX_V) ? MAX_V : load_val;
      prescaler <= '0;
      tc        <= 1'b0;
    end else if (en) begin
      if (step) begin
        prescaler <= '0;
        if (up) begin
          if (count == MAX_V) begin
            count <= sat ? MAX_V : ZERO_V;
            tc    <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
            tc    <= 1'b0;
          end
        end else begin
          if (count == ZERO_V) begin
            count <= sat ? ZERO_V : MAX_V;
            tc    <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
            tc    <= 1'b0;
          end
        end
      end else begin
        prescaler <= prescaler + PW'(1);
        tc        <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - scoreboard bench for updown_mod_counter
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] cnt_a, cnt_c;
  logic [2:0] cnt_b;
  logic       tc_a, tc_b, tc_c;
  logic       az_a, az_b, az_c;
  logic       am_a, am_b, am_c;

  always #5 clk = ~clk;

  // a: 4-bit mod 9, no prescale; b: 3-bit mod 7; c: 4-bit mod 9, prescale 3
  updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(cnt_a), .tc(tc_a), .at_zero(az_a), .at_max(am_a));

  updown_mod_counter #(.WIDTH(3), .MOD_MAX(7)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val[2:0]), .count(cnt_b), .tc(tc_b), .at_zero(az_b), .at_max(am_b));

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(3)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(cnt_c), .tc(tc_c), .at_zero(az_c), .at_max(am_c));

  typedef struct packed {
    logic       chk;
    logic [1:0] sel;
    logic [3:0] cnt;
    logic       tc;
    logic       az;
    logic       am;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [1:0] cur_sel = 2'd0;

  task automatic check1(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the counter presents a result every cycle, so one entry is consumed per edge.
  always begin
    exp_t e;
    logic [3:0] c;
    logic t, z, m;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        2'd0:    begin c = cnt_a;        t = tc_a; z = az_a; m = am_a; end
        2'd1:    begin c = {1'b0, cnt_b}; t = tc_b; z = az_b; m = am_b; end
        default: begin c = cnt_c;        t = tc_c; z = az_c; m = am_c; end
      endcase
      if (e.chk) begin
        check1($sformatf("count[dut%0d]", e.sel), int'(c), int'(e.cnt));
        check1($sformatf("tc[dut%0d]", e.sel), int'(t), int'(e.tc));
        check1($sformatf("at_zero[dut%0d]", e.sel), int'(z), int'(e.az));
        check1($sformatf("at_max[dut%0d]", e.sel), int'(m), int'(e.am));
      end
    end
  end

  // Drive one cycle of inputs and queue the expected post-edge state of the selected DUT.
  task automatic cyc(input logic rst_n, input logic ld, input logic [3:0] lv,
                     input logic e, input logic u, input logic s,
                     input logic chk, input int ecnt, input logic etc);
    exp_t x;
    int mx;
    @(negedge clk);
    reset = rst_n; load = ld; load_val = lv; en = e; up = u; sat = s;
    mx = (cur_sel == 2'd1) ? 7 : 9;
    x.chk = chk;
    x.sel = cur_sel;
    x.cnt = 4'(ecnt);
    x.tc  = etc;
    x.az  = (ecnt == 0);
    x.am  = (ecnt == mx);
    sb.push_back(x);
  endtask

  initial begin
    int seq_b[9];
    seq_b = '{6, 5, 4, 3, 2, 1, 0, 7, 6};

    // 3-bit mod 7 free-running down count from reset
    cur_sel = 2'd1;
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 0);
    for (int i = 0; i < 9; i++)
      cyc(1, 0, 0, 1, 0, 0, 1, seq_b[i], (seq_b[i] == 7));

    // mod 9 load, wrap up, clamp
    cur_sel = 2'd0;
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(1, 1, 8, 0, 0, 0, 1, 8, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 9, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 0, 1);
    cyc(1, 0, 0, 1, 1, 0, 1, 1, 0);
    cyc(1, 1, 14, 0, 0, 0, 1, 9, 0);
    // saturate down from 1
    cyc(1, 1, 1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 1, 1, 0, 1);
    cyc(1, 0, 0, 1, 0, 1, 1, 0, 1);
    cyc(1, 0, 0, 1, 0, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
    // saturate up at max, then hold with en low
    cyc(1, 1, 8, 0, 0, 0, 1, 8, 0);
    cyc(1, 0, 0, 1, 1, 1, 1, 9, 0);
    cyc(1, 0, 0, 1, 1, 1, 1, 9, 1);
    cyc(1, 0, 0, 0, 1, 1, 1, 9, 0);
    // reset beats load; load beats a boundary step
    cyc(0, 1, 2, 1, 1, 0, 1, 9, 0);
    cyc(1, 1, 2, 1, 1, 0, 1, 2, 0);
    // reset mid-count, then resume
    cyc(1, 1, 3, 0, 1, 0, 1, 3, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 4, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 5, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, 9, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 0, 1);
    cyc(1, 0, 0, 1, 1, 0, 1, 1, 0);

    // prescale 3
    cur_sel = 2'd2;
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 2, 0);
    // en dropped for 2 cycles mid-prescale stretches the interval by 2
    cyc(1, 0, 0, 1, 1, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 1, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 1, 0, 1, 2, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 2, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 3, 0);
    // load clears a partially advanced prescaler
    cyc(1, 0, 0, 1, 1, 0, 1, 3, 0);
    cyc(1, 1, 5, 1, 1, 0, 1, 5, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 5, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 5, 0);
    cyc(1, 0, 0, 1, 1, 0, 1, 6, 0);
    // direction change mid-prescale applies at the next step
    cyc(1, 0, 0, 1, 1, 0, 1, 6, 0);
    cyc(1, 0, 0, 1, 0, 0, 1, 6, 0);
    cyc(1, 0, 0, 1, 0, 0, 1, 5, 0);

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
